life_cell_rule: RTL and testbench
=================================

Name: life_cell_rule

Overview:
- Registered Game-of-Life cell with a parametrised neighbour count and two selectable rule sets.
- Generalises the fixed 8-input "exactly one live neighbour" detector into a population counter. It applies birth/survive masks indexed by neighbour count and holds cell state across generations.
- Adds a saturating age counter and a change pulse. One instance sits per grid cell; the grid controller drives load/step.

Parameters:
N_NEIGH, 8, number of neighbour inputs (1..15)
AGE_W, 4, width of saturating age counter (>=1)
BIRTH0, 9'b000001000, rule set 0 birth mask; bit k set = dead cell with k live neighbours is born (Conway B3); width N_NEIGH+1
SURVIVE0, 9'b000001100, rule set 0 survive mask (Conway S23); width N_NEIGH+1
BIRTH1, 9'b001001000, rule set 1 birth mask (HighLife B36)
SURVIVE1, 9'b000001100, rule set 1 survive mask (HighLife S23)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  write load_val into cell state this cycle
load_val  input  1  value written on load
step  input  1  advance one generation this cycle
rule_sel  input  1  0 = BIRTH0/SURVIVE0, 1 = BIRTH1/SURVIVE1; sampled only on step
neigh  input  N_NEIGH  live flags of neighbours; sampled only on step
alive  output  1  registered cell state
count  output  CW  registered neighbour count from last step, CW = $clog2(N_NEIGH+1)
age  output  AGE_W  generations survived since birth/load, saturating
changed  output  1  one-cycle pulse: last step flipped alive

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All outputs are registered.
- Reset values: alive=0, count=0, age=0, changed=0.
- Priority: reset > load > step > hold.
- Load cycle:
  - alive<=load_val, age<=0, changed<=0.
  - count holds its value.
  - A step asserted in the same cycle is ignored.
- Step cycle:
  - cnt = popcount(neigh), zero-extended to CW bits.
  - Masks are selected by rule_sel.
  - nxt = alive ? SURVIVE[cnt] : BIRTH[cnt].
  - Registered updates: alive<=nxt, count<=cnt, changed<=(nxt!=alive).
- Age rules on step:
  - alive & nxt: age<=age+1, saturating at 2^AGE_W-1; no wrap to 0.
  - ~alive & nxt (birth): age<=0.
  - ~nxt: age<=0.
- Latency: outputs reflect a step or load one cycle after the qualifying edge. Back-to-back steps on every cycle are supported, with one generation per cycle.
- Hold cycle (no reset/load/step): alive, count and age hold; changed<=0.
  - changed is therefore never high for two cycles unless consecutive steps each flip the state.
- Boundaries:
  - Mask bit N_NEIGH covers the all-neighbours-live case; cnt never exceeds N_NEIGH.
  - neigh=0 indexes mask bit 0.
  - Reset asserted mid-run with step or load high: reset wins and all outputs take reset values next cycle.
  - rule_sel changes between steps take effect on the next step only. No internal state depends on rule_sel.
- Purely synchronous. No combinational paths from inputs to outputs.

Test Plan:
- Reset: assert reset with load=1, load_val=1, step=1 -> next cycle alive=0, count=0, age=0, changed=0.
- Survive and age (default params):
  - Step 1: load 1, then step with neigh=8'b00000011 -> alive=1, count=2, age=1, changed=0.
  - Step 2: step again, neigh=8'b00000111 -> count=3, age=2.
- Birth/death pulse:
  - Birth: alive=0, step with neigh=8'b10100001 -> alive=1, count=3, age=0, changed=1 for exactly one cycle, then 0 on the idle cycle.
  - Death: step with neigh=8'h01 -> alive=0, count=1, changed=1.
  - Full count: step with neigh=8'hFF -> count=8, alive stays 0.
- Age saturation: AGE_W=2, load 1, five steps with neigh=8'b00000011 -> age 1,2,3,3,3 with alive=1 throughout.
- Rule select:
  - Dead cell, neigh=8'b00111111 (6 live), rule_sel=0 -> stays dead.
  - Same stimulus, rule_sel=1 -> alive=1, changed=1.
- Priority: load=1, load_val=0, step=1 with alive=1, neigh=3 live -> alive=0, age=0, changed=0, count unchanged. Also run N_NEIGH=4 with 5-bit masks and neigh=4'hF -> count=4.

Source files
------------

// File: rtl/life_cell_rule_if.sv
// Control/status bundle between the grid controller (master) and one
// Game-of-Life cell (slave).
interface life_cell_rule_if #(
  parameter int N_NEIGH = 8,
  parameter int AGE_W   = 4
);
  localparam int CW = $clog2(N_NEIGH + 1);

  logic               load;
  logic               load_val;
  logic               step;
  logic               rule_sel;
  logic [N_NEIGH-1:0] neigh;
  logic               alive;
  logic [CW-1:0]      count;
  logic [AGE_W-1:0]   age;
  logic               changed;

  modport master (
    output load, load_val, step, rule_sel, neigh,
    input  alive, count, age, changed
  );

  modport slave (
    input  load, load_val, step, rule_sel, neigh,
    output alive, count, age, changed
  );
endinterface

// File: rtl/life_cell_rule.sv
// Registered Game-of-Life cell: neighbour population count, selectable
// birth/survive masks, saturating age counter and a one-cycle change pulse.
module life_cell_rule #(
  parameter int               N_NEIGH  = 8,
  parameter int               AGE_W    = 4,
  parameter logic [N_NEIGH:0] BIRTH0   = 9'b000001000,
  parameter logic [N_NEIGH:0] SURVIVE0 = 9'b000001100,
  parameter logic [N_NEIGH:0] BIRTH1   = 9'b001001000,
  parameter logic [N_NEIGH:0] SURVIVE1 = 9'b000001100
) (
  input  logic             clk,
  input  logic             reset,
  life_cell_rule_if.slave  bus
);
  localparam int CW = $clog2(N_NEIGH + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  function automatic logic [CW-1:0] popcount(input logic [N_NEIGH-1:0] v);
    logic [CW-1:0] acc;
    acc = {CW{1'b0}};
    for (int i = 0; i < N_NEIGH; i++) begin
      acc = acc + CW'(v[i]);
    end
    return acc;
  endfunction

  logic             r_alive;
  logic [CW-1:0]    r_count;
  logic [AGE_W-1:0] r_age;
  logic             r_changed;

  logic [CW-1:0]    w_cnt;
  logic [N_NEIGH:0] w_birth;
  logic [N_NEIGH:0] w_survive;
  logic             w_nxt;
  logic [AGE_W-1:0] w_step_age;

  logic             w_alive_d;
  logic [CW-1:0]    w_count_d;
  logic [AGE_W-1:0] w_age_d;
  logic             w_changed_d;

  // Rule evaluation: count live neighbours and look up the selected mask.
  always_comb begin
    w_cnt     = popcount(bus.neigh);
    w_birth   = bus.rule_sel ? BIRTH1 : BIRTH0;
    w_survive = bus.rule_sel ? SURVIVE1 : SURVIVE0;
    w_nxt     = r_alive ? w_survive[w_cnt] : w_birth[w_cnt];
    // Only a surviving cell ages; births and deaths restart at zero.
    if (r_alive && w_nxt) begin
      if (r_age == AGE_MAX) begin
        w_step_age = AGE_MAX;
      end else begin
        w_step_age = r_age + {{(AGE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      w_step_age = {AGE_W{1'b0}};
    end
  end

  // Next-state selection: load beats step, otherwise hold with pulse cleared.
  always_comb begin
    w_alive_d   = r_alive;
    w_count_d   = r_count;
    w_age_d     = r_age;
    w_changed_d = 1'b0;
    if (bus.load) begin
      w_alive_d   = bus.load_val;
      w_age_d     = {AGE_W{1'b0}};
      w_changed_d = 1'b0;
    end else if (bus.step) begin
      w_alive_d   = w_nxt;
      w_count_d   = w_cnt;
      w_age_d     = w_step_age;
      w_changed_d = (w_nxt != r_alive);
    end else begin
      w_changed_d = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alive   <= 1'b0;
      r_count   <= {CW{1'b0}};
      r_age     <= {AGE_W{1'b0}};
      r_changed <= 1'b0;
    end else begin
      r_alive   <= w_alive_d;
      r_count   <= w_count_d;
      r_age     <= w_age_d;
      r_changed <= w_changed_d;
    end
  end

  assign bus.alive   = r_alive;
  assign bus.count   = r_count;
  assign bus.age     = r_age;
  assign bus.changed = r_changed;
endmodule

// File: tb/tb_life_cell_rule.sv
// Bench for life_cell_rule: three configurations driven in lockstep and
// checked every cycle against an arithmetic model plus literal expectations.
module tb_life_cell_rule;
  logic clk;
  logic reset;
  logic t_load, t_load_val, t_step, t_rule_sel;
  logic [7:0] t_neigh;
  bit   chk_en;
  int   n_pass;
  int   n_total;

  life_cell_rule_if #(.N_NEIGH(8), .AGE_W(4)) bus0 ();
  life_cell_rule_if #(.N_NEIGH(8), .AGE_W(2)) bus1 ();
  life_cell_rule_if #(.N_NEIGH(4), .AGE_W(4)) bus2 ();

  assign bus0.load = t_load;  assign bus0.load_val = t_load_val;
  assign bus0.step = t_step;  assign bus0.rule_sel = t_rule_sel;
  assign bus0.neigh = t_neigh;
  assign bus1.load = t_load;  assign bus1.load_val = t_load_val;
  assign bus1.step = t_step;  assign bus1.rule_sel = t_rule_sel;
  assign bus1.neigh = t_neigh;
  assign bus2.load = t_load;  assign bus2.load_val = t_load_val;
  assign bus2.step = t_step;  assign bus2.rule_sel = t_rule_sel;
  assign bus2.neigh = t_neigh[3:0];

  life_cell_rule #(.N_NEIGH(8), .AGE_W(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  life_cell_rule #(.N_NEIGH(8), .AGE_W(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  life_cell_rule #(
    .N_NEIGH(4), .AGE_W(4),
    .BIRTH0(5'b01000), .SURVIVE0(5'b01100),
    .BIRTH1(5'b10000), .SURVIVE1(5'b01100)
  ) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance rule description: neighbour count, age width, masks.
  int nn [3] = '{8, 8, 4};
  int aw [3] = '{4, 2, 4};
  int b0 [3] = '{'h008, 'h008, 'h08};
  int s0 [3] = '{'h00C, 'h00C, 'h0C};
  int b1 [3] = '{'h048, 'h048, 'h10};
  int s1 [3] = '{'h00C, 'h00C, 'h0C};

  int m_alive   [3];
  int m_count   [3];
  int m_age     [3];
  int m_changed [3];

  function automatic int f_cnt(int k, logic [7:0] n);
    int c;
    c = 0;
    for (int i = 0; i < nn[k]; i++) c += int'(n[i]);
    return c;
  endfunction

  function automatic int f_nxt(int k, int alive, int cnt, logic rs);
    int mask;
    if (alive != 0) mask = rs ? s1[k] : s0[k];
    else            mask = rs ? b1[k] : b0[k];
    return (mask >> cnt) & 1;
  endfunction

  function automatic int f_age(int k, int alive, int nxt, int age);
    int amax;
    amax = (1 << aw[k]) - 1;
    if (alive != 0 && nxt != 0) return (age >= amax) ? amax : age + 1;
    return 0;
  endfunction

  // Reference model, advanced on every rising edge from the driven inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_alive[k] <= 0; m_count[k] <= 0; m_age[k] <= 0; m_changed[k] <= 0;
      end else if (t_load) begin
        m_alive[k] <= int'(t_load_val); m_age[k] <= 0; m_changed[k] <= 0;
      end else if (t_step) begin
        m_alive[k]   <= f_nxt(k, m_alive[k], f_cnt(k, t_neigh), t_rule_sel);
        m_count[k]   <= f_cnt(k, t_neigh);
        m_age[k]     <= f_age(k, m_alive[k],
                              f_nxt(k, m_alive[k], f_cnt(k, t_neigh), t_rule_sel), m_age[k]);
        m_changed[k] <= (f_nxt(k, m_alive[k], f_cnt(k, t_neigh), t_rule_sel) != m_alive[k]) ? 1 : 0;
      end else begin
        m_changed[k] <= 0;
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("c0.alive", int'(bus0.alive), m_alive[0]);
      chk("c0.count", int'(bus0.count), m_count[0]);
      chk("c0.age", int'(bus0.age), m_age[0]);
      chk("c0.changed", int'(bus0.changed), m_changed[0]);
      chk("c1.alive", int'(bus1.alive), m_alive[1]);
      chk("c1.count", int'(bus1.count), m_count[1]);
      chk("c1.age", int'(bus1.age), m_age[1]);
      chk("c1.changed", int'(bus1.changed), m_changed[1]);
      chk("c2.alive", int'(bus2.alive), m_alive[2]);
      chk("c2.count", int'(bus2.count), m_count[2]);
      chk("c2.age", int'(bus2.age), m_age[2]);
      chk("c2.changed", int'(bus2.changed), m_changed[2]);
    end
  end

  task automatic cyc(logic r, logic ld, logic lv, logic st, logic rs, logic [7:0] n);
    reset = r; t_load = ld; t_load_val = lv; t_step = st; t_rule_sel = rs; t_neigh = n;
    @(posedge clk);
    #1;
  endtask

  task automatic lit0(string name, int a, int c, int g, int ch);
    chk({name, ".alive"}, int'(bus0.alive), a);
    chk({name, ".count"}, int'(bus0.count), c);
    chk({name, ".age"}, int'(bus0.age), g);
    chk({name, ".changed"}, int'(bus0.changed), ch);
  endtask

  initial begin
    n_pass = 0; n_total = 0; chk_en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b1;
    lit0("rst0", 0, 0, 0, 0);

    // Survive and age
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    lit0("load1", 1, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00000011);
    lit0("surv1", 1, 2, 1, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00000111);
    lit0("surv2", 1, 3, 2, 0);

    // Reset beats load and step
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    lit0("rstwin", 0, 0, 0, 0);
    chk("rstwin.c2count", int'(bus2.count), 0);

    // Birth, idle, death, full count
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b10100001);
    lit0("birth", 1, 3, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    lit0("idle", 1, 3, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    lit0("death", 0, 1, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    lit0("full", 0, 8, 0, 0);
    chk("full.c2count", int'(bus2.count), 4);

    // Age saturation on the 2-bit age instance
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00000011);
      chk("sat.c1age", int'(bus1.age), (i < 3) ? i + 1 : 3);
      chk("sat.c1alive", int'(bus1.alive), 1);
      chk("sat.c0age", int'(bus0.age), i + 1);
    end

    // Rule select: six live neighbours only bear under HighLife
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'b00111111);
    lit0("rule0", 0, 6, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b00111111);
    lit0("rule1", 1, 6, 0, 1);
    chk("rule1.c2alive", int'(bus2.alive), 1);

    // Load beats step; count holds
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'b00000111);
    lit0("prio", 0, 6, 0, 0);

    // Back-to-back directed sweep checked by the model
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, (i == 17) ? 1'b1 : 1'b0, 1'b1, (i % 5 != 4) ? 1'b1 : 1'b0,
          (i % 3 == 0) ? 1'b1 : 1'b0, 8'((i * 29 + 7) ^ (i * 3)));
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
